// File: rtl/bitwise_logic_unit_seq_if.sv
// Handshake bundle for the sliced bitwise logic unit.
// Request side: in_valid/in_ready, op, a, b.
// Result side: out_valid/out_ready, res, zero, ones.
interface bitwise_logic_unit_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             zero;
  logic             ones;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res, zero, ones
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res, zero, ones
  );
endinterface

// File: rtl/bitwise_logic_unit_seq.sv
// Sliced bitwise logic lane: one of eight functions, SLICE bits/clock.
// Ports: clk, reset (async, active-high), bus (slave handshake bundle).
module bitwise_logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic                     clk,
  input logic                     reset,
  bitwise_logic_unit_seq_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_ones;

  logic [31:0]      w_base;
  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic [SLICE-1:0] w_slice;
  logic [WIDTH-1:0] w_res;
  logic             w_acc;
  logic             w_last;

  assign w_base = 32'(r_cnt) * 32'(SLICE);
  assign w_acc  = (r_state == S_IDLE) && bus.in_valid;
  assign w_last = (r_cnt == LAST);

  always_comb begin
    w_sa    = r_a[w_base +: SLICE];
    w_sb    = r_b[w_base +: SLICE];
    w_slice = '0;
    unique case (r_op)
      3'b000:  w_slice = w_sa & w_sb;
      3'b001:  w_slice = w_sa | w_sb;
      3'b010:  w_slice = w_sa ^ w_sb;
      3'b011:  w_slice = ~(w_sa & w_sb);
      3'b100:  w_slice = ~(w_sa | w_sb);
      3'b101:  w_slice = ~(w_sa ^ w_sb);
      3'b110:  w_slice = w_sa & ~w_sb;
      default: w_slice = w_sa;
    endcase
  end

  // Merged view of the result after this cycle's slice; the flags
  // are taken from it on the final slice so they see the whole word.
  always_comb begin
    w_res = r_res;
    w_res[w_base +: SLICE] = w_slice;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_BUSY;
      S_BUSY:  if (w_last) w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_zero <= 1'b0;
      r_ones <= 1'b0;
    end else begin
      if (w_acc) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_op  <= bus.op;
        r_cnt <= '0;
      end
      if (r_state == S_BUSY) begin
        r_res <= w_res;
        if (w_last) begin
          r_zero <= ~|w_res;
          r_ones <= &w_res;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      // Counter parks on the last slice in DONE and
      // is cleared only when the result is taken.
      if ((r_state == S_DONE) && bus.out_ready)
        r_cnt <= '0;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.res       = r_res;
  assign bus.zero      = r_zero;
  assign bus.ones      = r_ones;

endmodule

// File: tb/tb_bitwise_logic_unit_seq.sv
// Bench for bitwise_logic_unit_seq at (32,8), (32,32), (64,16).
// Directed cases plus random ops against a word-level model.
module tb_bitwise_logic_unit_seq;

  logic clk;
  logic reset;

  bitwise_logic_unit_seq_if #(.WIDTH(32)) bus0 ();
  bitwise_logic_unit_seq_if #(.WIDTH(32)) bus1 ();
  bitwise_logic_unit_seq_if #(.WIDTH(64)) bus2 ();

  bitwise_logic_unit_seq #(.WIDTH(32), .SLICE(8)) u0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  bitwise_logic_unit_seq #(.WIDTH(32), .SLICE(32)) u1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );
  bitwise_logic_unit_seq #(.WIDTH(64), .SLICE(16)) u2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  logic        v    [3];
  logic        ordy [3];
  logic [2:0]  opx  [3];
  logic [63:0] ax   [3];
  logic [63:0] bx   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        zo   [3];
  logic        oo   [3];
  logic [63:0] ro   [3];

  assign bus0.in_valid  = v[0];
  assign bus0.out_ready = ordy[0];
  assign bus0.op        = opx[0];
  assign bus0.a         = ax[0][31:0];
  assign bus0.b         = bx[0][31:0];
  assign bus1.in_valid  = v[1];
  assign bus1.out_ready = ordy[1];
  assign bus1.op        = opx[1];
  assign bus1.a         = ax[1][31:0];
  assign bus1.b         = bx[1][31:0];
  assign bus2.in_valid  = v[2];
  assign bus2.out_ready = ordy[2];
  assign bus2.op        = opx[2];
  assign bus2.a         = ax[2];
  assign bus2.b         = bx[2];

  assign ir[0] = bus0.in_ready;
  assign ov[0] = bus0.out_valid;
  assign zo[0] = bus0.zero;
  assign oo[0] = bus0.ones;
  assign ro[0] = {32'h0, bus0.res};
  assign ir[1] = bus1.in_ready;
  assign ov[1] = bus1.out_valid;
  assign zo[1] = bus1.zero;
  assign oo[1] = bus1.ones;
  assign ro[1] = {32'h0, bus1.res};
  assign ir[2] = bus2.in_ready;
  assign ov[2] = bus2.out_valid;
  assign zo[2] = bus2.zero;
  assign oo[2] = bus2.ones;
  assign ro[2] = bus2.res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int wid(int u);
    return (u == 2) ? 64 : 32;
  endfunction

  function automatic int nsl(int u);
    return (u == 1) ? 1 : 4;
  endfunction

  function automatic logic [63:0] msk(int u);
    return (u == 2) ? 64'hFFFF_FFFF_FFFF_FFFF
                    : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] model(logic [2:0] op,
                                        logic [63:0] a,
                                        logic [63:0] b,
                                        logic [63:0] m);
    logic [63:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = ~(a ^ b);
      3'd6:    r = a & ~b;
      default: r = a;
    endcase
    return r & m;
  endfunction

  task automatic wait_ov(int u, output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (ov[u]) break;
    end
  endtask

  task automatic run_op(int u, logic [2:0] op,
                        logic [63:0] a, logic [63:0] b,
                        int hold, bit poke, string tag);
    logic [63:0] m;
    logic [63:0] e;
    int lat;
    m = msk(u);
    e = model(op, a & m, b & m, m);
    @(negedge clk);
    chk({tag, "/rdy"}, 64'(ir[u]), 64'd1);
    v[u]    = 1'b1;
    opx[u]  = op;
    ax[u]   = a & m;
    bx[u]   = b & m;
    ordy[u] = 1'b0;
    @(posedge clk);
    #1;
    if (poke) begin
      opx[u] = 3'b001;
      ax[u]  = ~a & m;
      bx[u]  = ~b & m;
    end else begin
      v[u] = 1'b0;
    end
    wait_ov(u, lat);
    chk({tag, "/lat"}, 64'(lat), 64'(nsl(u)));
    chk({tag, "/res"}, ro[u], e);
    chk({tag, "/flg"}, {62'h0, zo[u], oo[u]},
        {62'h0, e == 64'h0, e == m});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "/hres"}, ro[u], e);
      chk({tag, "/hsig"},
          {60'h0, ov[u], ir[u], zo[u], oo[u]},
          {60'h0, 1'b1, 1'b0, e == 64'h0, e == m});
    end
    v[u]    = 1'b0;
    ordy[u] = 1'b1;
    @(posedge clk);
    #1;
    ordy[u] = 1'b0;
    chk({tag, "/ret"}, {62'h0, ov[u], ir[u]}, 64'd1);
    chk({tag, "/keep"}, ro[u], e);
  endtask

  task automatic back_to_back();
    int lat;
    @(negedge clk);
    ordy[0] = 1'b1;
    v[0]    = 1'b1;
    opx[0]  = 3'b001;
    ax[0]   = 64'h1234_0000;
    bx[0]   = 64'h0000_5678;
    @(posedge clk);
    #1;
    chk("b2b/acc1", 64'(ir[0]), 64'd0);
    opx[0] = 3'b111;
    ax[0]  = 64'hDEAD_BEEF;
    bx[0]  = 64'h0;
    wait_ov(0, lat);
    chk("b2b/lat1", 64'(lat), 64'd4);
    chk("b2b/res1", ro[0], 64'h1234_5678);
    @(posedge clk);
    #1;
    chk("b2b/idle", {62'h0, ov[0], ir[0]}, 64'd1);
    @(posedge clk);
    #1;
    chk("b2b/acc2", 64'(ir[0]), 64'd0);
    v[0] = 1'b0;
    wait_ov(0, lat);
    chk("b2b/lat2", 64'(lat), 64'd4);
    chk("b2b/res2", ro[0], 64'hDEAD_BEEF);
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    chk("b2b/ret", {62'h0, ov[0], ir[0]}, 64'd1);
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    v[0]   = 1'b1;
    opx[0] = 3'b000;
    ax[0]  = 64'hFFFF_FFFF;
    bx[0]  = 64'hFFFF_FFFF;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mrst/sig", {60'h0, ov[0], ir[0], zo[0], oo[0]},
        64'b0100);
    chk("mrst/res", ro[0], 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("mrst/nov", 64'(ov[0]), 64'd0);
    end
    run_op(0, 3'b000, 64'hFFFF_FFFF, 64'hFFFF_FFFF,
           0, 1'b0, "mrst/op");
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      v[u]    = 1'b0;
      ordy[u] = 1'b0;
      opx[u]  = 3'b0;
      ax[u]   = 64'h0;
      bx[u]   = 64'h0;
    end
    reset = 1'b1;
    #12;
    for (int u = 0; u < 3; u++) begin
      chk("rst/sig", {60'h0, ov[u], ir[u], zo[u], oo[u]},
          64'b0100);
      chk("rst/res", ro[u], 64'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int u = 0; u < 3; u++)
      run_op(u, 3'b000, 64'h9, 64'hA, 0, 1'b0, "and");
    run_op(0, 3'b010, 64'hFFFF_0000, 64'hFFFF_0000,
           0, 1'b0, "xor");
    run_op(0, 3'b101, 64'hFFFF_0000, 64'hFFFF_0000,
           0, 1'b0, "xnor");
    run_op(0, 3'b110, 64'hF0F0_F0F0, 64'hFF00_FF00,
           0, 1'b0, "andn");
    run_op(0, 3'b000, 64'h9, 64'hA, 10, 1'b1, "bp");
    run_op(2, 3'b101, 64'h0123_4567_89AB_CDEF,
           64'h0123_4567_89AB_CDEF, 2, 1'b1, "xnor64");
    back_to_back();
    reset_mid_op();

    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < 25; k++) begin
        run_op(u, 3'($urandom_range(0, 7)),
               {$urandom, $urandom}, {$urandom, $urandom},
               int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
